// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues boot RAM reads, absorbs the one-cycle
// read latency and queues {pc, instr} pairs for decode behind a valid/ready handshake.
module instr_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] instr_rd_addr,
    output logic            instr_rd_en,
    input  logic [XLEN-1:0] instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] inflight_pc_r;
    logic            inflight_r;
    logic [XLEN-1:0] fifo_pc_r    [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_instr_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    logic            pop_s;
    logic            push_s;
    logic            issue_s;
    logic [CW:0]     credit_s;
    logic [XLEN-1:0] redirect_target_s;

    assign if_valid          = (count_r != '0);
    assign pop_s             = if_valid & if_ready;
    assign redirect_target_s = redirect_pc & ~XLEN'(3);
    assign instr_rd_addr     = pc_r;
    assign instr_rd_en       = issue_s;
    assign if_pc             = fifo_pc_r[rd_ptr_r];
    assign if_instr          = fifo_instr_r[rd_ptr_r];

    // Credit check: buffered plus in-flight words, less the one leaving now, must leave a free slot
    always_comb begin
        credit_s = {1'b0, count_r} + (CW + 1)'(inflight_r) - (CW + 1)'(pop_s);
        push_s   = inflight_r & ~redirect_valid;
        if (rst || redirect_valid) begin
            issue_s = 1'b0;
        end else begin
            issue_s = (credit_s < DEPTH_C);
        end
    end

    // Program counter and in-flight read tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
        end else if (redirect_valid) begin
            pc_r          <= redirect_target_s;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end else if (issue_s) begin
            pc_r          <= pc_r + XLEN'(4);
            inflight_r    <= 1'b1;
            inflight_pc_r <= pc_r;
        end else begin
            pc_r          <= pc_r;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end
    end

    // FIFO occupancy and pointers; a flush keeps the read pointer so the stale head stays stable
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (redirect_valid) begin
            count_r  <= '0;
            wr_ptr_r <= rd_ptr_r;
            rd_ptr_r <= rd_ptr_r;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            wr_ptr_r <= push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        end
    end

    // FIFO storage: returning RAM word is tagged with the PC it was fetched from
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_r[i]    <= '0;
                fifo_instr_r[i] <= '0;
            end
        end else if (push_s) begin
            fifo_pc_r[wr_ptr_r]    <= inflight_pc_r;
            fifo_instr_r[wr_ptr_r] <= instr;
        end else begin
            fifo_pc_r[wr_ptr_r]    <= fifo_pc_r[wr_ptr_r];
            fifo_instr_r[wr_ptr_r] <= fifo_instr_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic checked against a
// queue-based model of issued fetches; a second instance covers PC wrap from the top of memory.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam logic [31:0] RPCW = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_rd_addr, instr, redirect_pc, if_pc, if_instr;
    logic        instr_rd_en, redirect_valid, if_valid, if_ready;
    logic [31:0] w_rd_addr, w_instr, w_pc, w_if_instr;
    logic        w_rd_en, w_valid;
    logic        w_ready = 1'b1;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0000_0000;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        int          rdy;
    } ent_t;
    ent_t        q[$];
    logic [31:0] fpc;
    int          cyc;
    int          w_cyc;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .instr_rd_addr(instr_rd_addr), .instr_rd_en(instr_rd_en),
        .instr(instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
    );

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RPCW), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst), .instr_rd_addr(w_rd_addr), .instr_rd_en(w_rd_en),
        .instr(w_instr), .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
        .if_valid(w_valid), .if_ready(w_ready), .if_pc(w_pc), .if_instr(w_if_instr)
    );

    // 2 KB boot RAM: word i holds 0x1000_0000 + i, higher addresses alias
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h1000_0000 + {23'd0, a[10:2]};
    endfunction

    // RAM models with one-cycle read latency; idle cycles return junk that must be ignored
    always @(posedge clk) begin
        instr   <= instr_rd_en ? word_of(instr_rd_addr) : $urandom;
        w_instr <= w_rd_en ? word_of(w_rd_addr) : $urandom;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic        exp_valid, exp_pop, exp_issue;
        logic [31:0] wexp;
        @(negedge clk);
        rst = r; redirect_valid = rv; redirect_pc = rpc; if_ready = rdy;
        #1;
        exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
        exp_pop   = exp_valid && rdy;
        exp_issue = !r && !rv && ((q.size() - int'(exp_pop)) < DEPTH);
        check_eq("rd_en", {31'd0, instr_rd_en}, {31'd0, exp_issue});
        check_eq("rd_addr", instr_rd_addr, fpc);
        check_eq("if_valid", {31'd0, if_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            check_eq("if_pc", if_pc, q[0].pc);
            check_eq("if_instr", if_instr, word_of(q[0].pc));
        end
        if (!r) begin
            check_eq("wrap_valid", {31'd0, w_valid}, {31'd0, (w_cyc >= 2)});
            if (w_cyc >= 2) begin
                wexp = RPCW + 32'(4 * (w_cyc - 2));
                check_eq("wrap_pc", w_pc, wexp);
                check_eq("wrap_instr", w_if_instr, word_of(wexp));
            end
        end
        if (r) begin
            q.delete();
            fpc   = RPC;
            w_cyc = 0;
        end else begin
            w_cyc++;
            if (rv) begin
                q.delete();
                fpc = rpc & 32'hFFFF_FFFC;
            end else begin
                if (exp_pop) void'(q.pop_front());
                if (exp_issue) begin
                    q.push_back('{pc: fpc, rdy: cyc + 2});
                    fpc = fpc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        redirect_valid = 1'b0; redirect_pc = 32'd0; if_ready = 1'b1;
        fpc = RPC; cyc = 0; w_cyc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_eq("reset_rd_en", {31'd0, instr_rd_en}, 32'd0);
        check_eq("reset_addr", instr_rd_addr, RPC);
        check_eq("reset_valid", {31'd0, if_valid}, 32'd0);
        check_eq("reset_if_pc", if_pc, 32'd0);
        check_eq("reset_if_instr", if_instr, 32'd0);
        check_eq("reset_wrap_addr", w_rd_addr, RPCW);

        // streaming with decode always ready, then a 5-cycle stall
        step(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
        // redirect to an unaligned target while stalled with a read in flight
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
        // redirect coincident with a pop and a RAM return, then back-to-back redirects
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0300, 1'b1);
        step(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
        // reset for one cycle with the FIFO non-empty
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 150) == 0, ($urandom % 12) == 0, $urandom, ($urandom % 4) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
